// File: rtl/game_pkg.sv
// Shared definitions for the game flow controller: state codes, player status
// codes and a width helper for parameter-derived port widths.
package game_pkg;

  typedef enum logic [2:0] {
    ST_START     = 3'd0,
    ST_PLAYING   = 3'd1,
    ST_LEVEL_INC = 3'd2,
    ST_WORLD_INC = 3'd3,
    ST_LIFE_INC  = 3'd4,
    ST_LOSE      = 3'd5,
    ST_WIN       = 3'd6,
    ST_DIED      = 3'd7
  } game_state_e;

  typedef enum logic [1:0] {
    PS_PLAYING  = 2'd0,
    PS_PASSED   = 2'd1,
    PS_DIED     = 2'd2,
    PS_RESERVED = 2'd3
  } player_status_e;

  // Bits needed to hold values 0..n-1, never less than one bit.
  function automatic int width_of(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/dwell_timer.sv
// Counts tick_en strobes after a clear; done holds once PAUSE_TICKS strobes
// have been seen, and is already true right after a clear when PAUSE_TICKS is 0.
module dwell_timer
  import game_pkg::*;
#(
  parameter  int PAUSE_TICKS = 60,
  localparam int CNT_W       = width_of(PAUSE_TICKS + 1)
) (
  input  logic clk,
  input  logic clear,
  input  logic tick_en,
  output logic done
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign done = (cnt_q == CNT_W'(PAUSE_TICKS));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (tick_en && !done) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

endmodule

// File: rtl/game_flow_ctrl.sv
// Game flow sequencer: start / play / level and world advance / bonus life /
// death / win-lose, with timed dwell in each transition state.
module game_flow_ctrl
  import game_pkg::*;
#(
  parameter  int NUM_WORLDS       = 4,
  parameter  int LEVELS_PER_WORLD = 5,
  parameter  int START_LIVES      = 3,
  parameter  int MAX_LIVES        = 9,
  parameter  int LIFE_BONUS_EVERY = 3,
  parameter  int PAUSE_TICKS      = 60,
  localparam int WORLD_W          = width_of(NUM_WORLDS),
  localparam int LEVEL_W          = width_of(LEVELS_PER_WORLD),
  localparam int LIVES_W          = width_of(MAX_LIVES + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_btn,
  input  logic               tick_en,
  input  logic [1:0]         player_status,
  output logic [2:0]         game_status,
  output logic [WORLD_W-1:0] world,
  output logic [LEVEL_W-1:0] level,
  output logic [LIVES_W-1:0] lives,
  output logic               level_load
);

  localparam int CLR_W     = width_of(NUM_WORLDS * LEVELS_PER_WORLD + 1);
  localparam int BONUS_DIV = (LIFE_BONUS_EVERY > 0) ? LIFE_BONUS_EVERY : 1;

  game_state_e        state_q, state_d;
  logic [WORLD_W-1:0] world_q, world_d;
  logic [LEVEL_W-1:0] level_q, level_d;
  logic [LIVES_W-1:0] lives_q, lives_d;
  logic [CLR_W-1:0]   cleared_q, cleared_d;
  logic               armed_q, armed_d;
  logic               start_prev_q, start_prev_d;
  logic               level_load_q, level_load_d;
  logic               start_rise;
  logic               dwell_clear;
  logic               dwell_done;
  logic               bonus_due;

  assign start_rise   = start_btn && !start_prev_q;
  assign start_prev_d = start_btn;

  assign bonus_due = (LIFE_BONUS_EVERY > 0)
                  && ((int'(cleared_q) % BONUS_DIV) == 0)
                  && (lives_q < LIVES_W'(MAX_LIVES));

  // Any state change restarts the dwell count, so each transition state
  // starts from zero no matter how it was entered.
  assign dwell_clear = !rst || (state_d != state_q);

  dwell_timer #(
    .PAUSE_TICKS(PAUSE_TICKS)
  ) u_dwell (
    .clk    (clk),
    .clear  (dwell_clear),
    .tick_en(tick_en),
    .done   (dwell_done)
  );

  always_comb begin
    state_d      = state_q;
    world_d      = world_q;
    level_d      = level_q;
    lives_d      = lives_q;
    cleared_d    = cleared_q;
    armed_d      = armed_q;
    level_load_d = 1'b0;

    case (state_q)
      ST_START: begin
        if (start_rise) begin
          state_d   = ST_PLAYING;
          world_d   = '0;
          level_d   = '0;
          lives_d   = LIVES_W'(START_LIVES);
          cleared_d = '0;
        end
      end

      ST_PLAYING: begin
        if (!armed_q) begin
          armed_d = (player_status == PS_PLAYING);
        end else if (player_status == PS_PASSED) begin
          if (level_q == LEVEL_W'(LEVELS_PER_WORLD - 1)) begin
            if (world_q == WORLD_W'(NUM_WORLDS - 1)) begin
              state_d = ST_WIN;
            end else begin
              state_d   = ST_WORLD_INC;
              world_d   = world_q + WORLD_W'(1);
              level_d   = '0;
              cleared_d = cleared_q + CLR_W'(1);
            end
          end else begin
            state_d   = ST_LEVEL_INC;
            level_d   = level_q + LEVEL_W'(1);
            cleared_d = cleared_q + CLR_W'(1);
          end
        end else if (player_status == PS_DIED) begin
          if (lives_q <= LIVES_W'(1)) begin
            state_d = ST_LOSE;
            lives_d = '0;
          end else begin
            state_d = ST_DIED;
            lives_d = lives_q - LIVES_W'(1);
          end
        end
      end

      ST_LEVEL_INC, ST_WORLD_INC: begin
        if (dwell_done) begin
          if (bonus_due) begin
            state_d = ST_LIFE_INC;
            lives_d = lives_q + LIVES_W'(1);
          end else begin
            state_d = ST_PLAYING;
          end
        end
      end

      ST_LIFE_INC, ST_DIED: begin
        if (dwell_done) begin
          state_d = ST_PLAYING;
        end
      end

      ST_LOSE, ST_WIN: begin
        if (start_rise) begin
          state_d = ST_START;
        end
      end

      default: state_d = ST_START;
    endcase

    // Every entry into play reloads the level and must re-arm on a clean status.
    if (state_d == ST_PLAYING && state_q != ST_PLAYING) begin
      armed_d      = 1'b0;
      level_load_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q      <= ST_START;
      world_q      <= '0;
      level_q      <= '0;
      lives_q      <= LIVES_W'(START_LIVES);
      cleared_q    <= '0;
      armed_q      <= 1'b0;
      start_prev_q <= 1'b1;
      level_load_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      world_q      <= world_d;
      level_q      <= level_d;
      lives_q      <= lives_d;
      cleared_q    <= cleared_d;
      armed_q      <= armed_d;
      start_prev_q <= start_prev_d;
      level_load_q <= level_load_d;
    end
  end

  assign game_status = state_q;
  assign world       = world_q;
  assign level       = level_q;
  assign lives       = lives_q;
  assign level_load  = level_load_q;

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Bench for game_flow_ctrl: directed scenarios with literal expectations, then
// randomized play, all checked every cycle against a behavioural game model.
module tb_game_flow_ctrl;

  localparam int NW    = 2;
  localparam int LPW   = 3;
  localparam int SL    = 3;
  localparam int ML    = 5;
  localparam int LBE   = 2;
  localparam int PT    = 4;
  localparam int TOTAL = NW * LPW;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_btn;
  logic       tick_en;
  logic [1:0] player_status;
  logic [2:0] game_status;
  logic [0:0] world;
  logic [1:0] level;
  logic [2:0] lives;
  logic       level_load;

  int tests = 0;
  int fails = 0;
  bit chk_on = 1'b0;

  // Model: progress is tracked as a global stage number (levels passed so far).
  int m_state, m_stage, m_lives, m_ticks;
  bit m_armed, m_prev, m_load;

  game_flow_ctrl #(
    .NUM_WORLDS      (NW),
    .LEVELS_PER_WORLD(LPW),
    .START_LIVES     (SL),
    .MAX_LIVES       (ML),
    .LIFE_BONUS_EVERY(LBE),
    .PAUSE_TICKS     (PT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_btn    (start_btn),
    .tick_en      (tick_en),
    .player_status(player_status),
    .game_status  (game_status),
    .world        (world),
    .level        (level),
    .lives        (lives),
    .level_load   (level_load)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    int  nxt;
    bit  rise;
    if (!rst) begin
      m_state = 0; m_stage = 0; m_lives = SL; m_ticks = 0;
      m_armed = 0; m_prev = 1; m_load = 0;
    end else begin
      rise   = start_btn && !m_prev;
      m_prev = start_btn;
      nxt    = m_state;
      if (m_state == 0) begin
        if (rise) begin nxt = 1; m_stage = 0; m_lives = SL; end
      end else if (m_state == 1) begin
        if (!m_armed) m_armed = (player_status == 2'd0);
        else if (player_status == 2'd1) begin
          if (m_stage == TOTAL - 1) nxt = 6;
          else begin
            m_stage = m_stage + 1;
            nxt = (m_stage % LPW == 0) ? 3 : 2;
          end
        end else if (player_status == 2'd2) begin
          m_lives = m_lives - 1;
          nxt = (m_lives == 0) ? 5 : 7;
        end
      end else if (m_state >= 2 && m_state <= 4 || m_state == 7) begin
        if (m_ticks >= PT) begin
          if ((m_state == 2 || m_state == 3) && LBE > 0 && m_stage % LBE == 0 && m_lives < ML) begin
            nxt = 4; m_lives = m_lives + 1;
          end else nxt = 1;
        end else if (tick_en) m_ticks = m_ticks + 1;
      end else begin
        if (rise) nxt = 0;
      end
      if (nxt != m_state) m_ticks = 0;
      m_load = (nxt == 1 && m_state != 1);
      if (m_load) m_armed = 0;
      m_state = nxt;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s got %0d exp %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("cyc_status", int'(game_status), m_state);
      chk("cyc_world",  int'(world),       m_stage / LPW);
      chk("cyc_level",  int'(level),       m_stage % LPW);
      chk("cyc_lives",  int'(lives),       m_lives);
      chk("cyc_load",   int'(level_load),  int'(m_load));
    end
  end

  // Literal expectation applied to both the DUT and the model.
  task automatic lit(input string name, input int st, input int w, input int l, input int lv);
    chk({name, "_status"}, int'(game_status), st);
    chk({name, "_world"},  int'(world),       w);
    chk({name, "_level"},  int'(level),       l);
    chk({name, "_lives"},  int'(lives),       lv);
    chk({name, "_mstate"}, m_state,           st);
    chk({name, "_mlives"}, m_lives,           lv);
  endtask

  task automatic press();
    start_btn = 1'b0; @(negedge clk);
    start_btn = 1'b1; @(negedge clk);
  endtask

  task automatic pass_level();
    player_status = 2'd0; @(negedge clk);
    player_status = 2'd1; @(negedge clk);
    player_status = 2'd0;
  endtask

  task automatic die();
    player_status = 2'd0; @(negedge clk);
    player_status = 2'd2; @(negedge clk);
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      tick_en = 1'b1; @(negedge clk);
      tick_en = 1'b0; @(negedge clk);
    end
  endtask

  task automatic wait_status(input string name, input int code, input int budget);
    int n = 0;
    while (int'(game_status) != code && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(name, int'(game_status), code);
  endtask

  initial begin
    rst = 1'b0; start_btn = 1'b1; tick_en = 1'b0; player_status = 2'd0;
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    lit("held_btn", 0, 0, 0, 3);
    chk("reset_load", int'(level_load), 0);

    press();
    lit("start", 1, 0, 0, 3);
    chk("start_load", int'(level_load), 1);
    @(negedge clk);
    chk("load_single", int'(level_load), 0);

    pass_level();  lit("lvl_inc0", 2, 0, 1, 3);
    ticks(PT);     wait_status("to_play_a", 1, 10);
    pass_level();  lit("lvl_inc1", 2, 0, 2, 3);
    ticks(PT);     wait_status("to_life_a", 4, 10);
    lit("life_a", 4, 0, 2, 4);
    ticks(PT);     wait_status("to_play_b", 1, 10);
    pass_level();  lit("world_inc", 3, 1, 0, 4);
    ticks(PT);     wait_status("to_play_c", 1, 10);
    pass_level();  lit("lvl_inc_w1", 2, 1, 1, 4);
    ticks(PT);     wait_status("to_life_b", 4, 10);
    lit("life_b", 4, 1, 1, 5);
    ticks(PT);     wait_status("to_play_d", 1, 10);
    pass_level();  lit("lvl_inc_max", 2, 1, 2, 5);
    ticks(PT);     wait_status("to_play_e", 1, 10);
    pass_level();  lit("win", 6, 1, 2, 5);
    player_status = 2'd2; repeat (3) @(negedge clk);
    lit("win_hold", 6, 1, 2, 5);
    press();       lit("win_to_start", 0, 1, 2, 5);

    press();       lit("start2", 1, 0, 0, 3);
    die();         lit("died2", 7, 0, 0, 2);
    ticks(PT);     wait_status("to_play_f", 1, 10);
    repeat (4) @(negedge clk);
    lit("held_died", 1, 0, 0, 2);
    die();         lit("died1", 7, 0, 0, 1);
    player_status = 2'd0;
    ticks(PT);     wait_status("to_play_g", 1, 10);
    die();         lit("lose", 5, 0, 0, 0);
    player_status = 2'd1; repeat (3) @(negedge clk);
    lit("lose_hold", 5, 0, 0, 0);
    press();       lit("lose_to_start", 0, 0, 0, 0);

    press();       lit("start3", 1, 0, 0, 3);
    pass_level();  lit("lvl_inc_r", 2, 0, 1, 3);
    ticks(2);
    rst = 1'b0; @(negedge clk);
    lit("rst_mid_dwell", 0, 0, 0, 3);
    chk("rst_load", int'(level_load), 0);
    rst = 1'b1; repeat (3) @(negedge clk);
    lit("rst_btn_held", 0, 0, 0, 3);
    press();       lit("start4", 1, 0, 0, 3);
    player_status = 2'd0; @(negedge clk);
    player_status = 2'd3; repeat (6) @(negedge clk);
    lit("rsvd_ignored", 1, 0, 0, 3);

    for (int i = 0; i < 4000; i++) begin
      int r;
      tick_en = 1'($urandom_range(0, 1));
      r = $urandom_range(0, 15);
      player_status = (r < 10) ? 2'd0 : (r < 13) ? 2'd1 : (r < 15) ? 2'd2 : 2'd3;
      if ($urandom_range(0, 5) == 0) start_btn = ~start_btn;
      rst = ($urandom_range(0, 299) == 0) ? 1'b0 : 1'b1;
      @(negedge clk);
    end

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/game_flow_ctrl.md
GAME_FLOW_CTRL -- requirements
Module: game_flow_ctrl

Interface
REQ-001 Parameter NUM_WORLDS, 4: number of worlds, at least 1.
REQ-002 Parameter LEVELS_PER_WORLD, 5: levels in each world, at least 1.
REQ-003 Parameter START_LIVES, 3: lives at game start, 1..MAX_LIVES.
REQ-004 Parameter MAX_LIVES, 9: lives saturation value.
REQ-005 Parameter LIFE_BONUS_EVERY, 3: cleared levels per bonus life; 0 disables the bonus.
REQ-006 Parameter PAUSE_TICKS, 60: tick_en pulses to dwell in each transition state.
REQ-007 clk  input  1  single system clock; all logic on its rising edge.
REQ-008 rst  input  1  reset, synchronous, active-low.
REQ-009 start_btn  input  1  debounced level; rising edge detected internally.
REQ-010 tick_en  input  1  one-cycle strobe that advances the dwell counter.
REQ-011 player_status  input  2  0 playing, 1 level passed, 2 died, 3 reserved (ignored).
REQ-012 game_status  output  3  current state code per REQ-014.
REQ-013 Outputs: world [clog2(NUM_WORLDS)] (0-based); level [clog2(LEVELS_PER_WORLD)] (0-based, within world); lives [clog2(MAX_LIVES+1)]; level_load [1] (one-cycle pulse).

Function
REQ-014 States/codes SHALL be: START 0, PLAYING 1, LEVEL_INC 2, WORLD_INC 3, LIFE_INC 4, LOSE 5, WIN 6, DIED 7; game_status SHALL be the registered code.
REQ-015 START: on start_btn rising edge -> PLAYING; same edge loads world=0, level=0, lives=START_LIVES, cleared=0, pulses level_load.
REQ-016 PLAYING SHALL act on player_status only when armed; armed clears on entry to PLAYING and sets after one cycle with player_status==0.
REQ-017 PLAYING armed, status 1, last level of last world -> WIN.
REQ-018 PLAYING armed, status 1, last level of a non-last world -> WORLD_INC; same edge: world+1, level=0, cleared+1.
REQ-019 PLAYING armed, status 1, otherwise -> LEVEL_INC; same edge: level+1, cleared+1.
REQ-020 PLAYING armed, status 2: lives==1 -> LOSE with lives=0; else -> DIED with lives-1.
REQ-021 LEVEL_INC, WORLD_INC, DIED, LIFE_INC SHALL exit after counting PAUSE_TICKS tick_en pulses (counter clears on entry); PAUSE_TICKS=0 exits on the cycle after entry.
REQ-022 LEVEL_INC/WORLD_INC exit: bonus due (LIFE_BONUS_EVERY>0, cleared mod LIFE_BONUS_EVERY==0, lives<MAX_LIVES) -> LIFE_INC with lives+1; else -> PLAYING.
REQ-023 LIFE_INC and DIED exit -> PLAYING; lives SHALL never exceed MAX_LIVES nor drop below 0.
REQ-024 level_load SHALL pulse for exactly one cycle coincident with every entry edge into PLAYING, never otherwise.
REQ-025 LOSE/WIN: hold all outputs; start_btn rising edge -> START; player_status ignored.
REQ-026 start_btn SHALL be ignored in PLAYING and transition states; a button held through reset SHALL NOT produce an edge.
REQ-027 cleared SHALL be wide enough for NUM_WORLDS*LEVELS_PER_WORLD without wrap.

Reset
REQ-028 rst low on a clock edge SHALL force START, world=0, level=0, lives=START_LIVES, cleared=0, dwell=0, armed=0, level_load=0, edge-detect history=1, regardless of state, including mid-dwell.

Structure
REQ-029 Shared package game_pkg SHALL hold the state codes and player_status codes.
REQ-030 Dwell counter SHALL be sub-module dwell_timer (inputs clear, tick_en; output done; parameter PAUSE_TICKS).
REQ-031 Single state register with one-hot-free binary encoding per REQ-014; all outputs registered.

Verification (NUM_WORLDS=2, LEVELS_PER_WORLD=3, START_LIVES=3, MAX_LIVES=5, LIFE_BONUS_EVERY=2, PAUSE_TICKS=4)
REQ-032 Reset, start edge -> PLAYING, world 0, level 0, lives 3, one level_load pulse.
REQ-033 Pass levels 0,1 -> LEVEL_INC (level 1), then LEVEL_INC (level 2) -> LIFE_INC lives 4 after 4 ticks -> PLAYING.
REQ-034 Pass level 2 world 0 -> WORLD_INC, world 1, level 0; then 3 more passes -> WIN; start edge -> START.
REQ-035 Three deaths from lives 3 -> DIED(2), DIED(1), LOSE(0); status 2 held across DIED exit does not decrement until status returns to 0.
REQ-036 rst low during LEVEL_INC dwell tick 2 -> START, lives 3, level_load 0; status 3 in PLAYING causes no transition.
